// File: rtl/acltx_arqbuf_if.sv
// acltx_arqbuf_if: bus bundle between the ACL TX ARQ buffer controller and its
// neighbours (MCU buffer loads, RX header results, TX slot timing, encoder
// read path). The controller uses the slave modport; the driver side uses
// the master modport.
`timescale 1ns/1ps

interface acltx_arqbuf_if #(
    parameter int unsigned LENW = 10
);
    // Connection control
    logic            connsnew_p;
    // MCU payload buffer side
    logic            mcu_bufwr_p;
    logic [LENW-1:0] mcu_buflen;
    logic            mcu_flush_p;
    // RX header results
    logic            rx_hdr_valid_p;
    logic            rx_arqn;
    logic            rx_flow;
    // TX slot timing and encoder read strobe
    logic            tx_slot_start_p;
    logic            py_rd_p;
    // Slot decision
    logic            sendnewpy;
    logic            sendoldpy;
    logic            send0py;
    logic            sendnull;
    logic            txSEQN;
    logic [LENW-1:0] txpylen;
    // Payload RAM read path
    logic [LENW:0]   py_rdaddr;
    logic            py_rdlast;
    // Buffer status pulses
    logic            buf_released_p;
    logic            bufwr_err_p;

    modport master (
        output connsnew_p, mcu_bufwr_p, mcu_buflen, mcu_flush_p,
               rx_hdr_valid_p, rx_arqn, rx_flow, tx_slot_start_p, py_rd_p,
        input  sendnewpy, sendoldpy, send0py, sendnull, txSEQN, txpylen,
               py_rdaddr, py_rdlast, buf_released_p, bufwr_err_p
    );

    modport slave (
        input  connsnew_p, mcu_bufwr_p, mcu_buflen, mcu_flush_p,
               rx_hdr_valid_p, rx_arqn, rx_flow, tx_slot_start_p, py_rd_p,
        output sendnewpy, sendoldpy, send0py, sendnull, txSEQN, txpylen,
               py_rdaddr, py_rdlast, buf_released_p, bufwr_err_p
    );
endinterface

// File: rtl/acltx_arqbuf.sv
// acltx_arqbuf: ACL transmit ARQ buffer controller for one logical transport.
// Two ping-pong payload buffers loaded by the MCU; at each TX slot the latched
// ARQN/FLOW select new, old, zero-length or null payload and drive SEQN, the
// payload length and the payload RAM read address.
// Optional feature macro: ACLTX_ZEROLEN_FLUSH_EN (zero-length flush packet and
// ZERO_OUT state). Without it a flushed NAK simply drops the buffer and idles.
`timescale 1ns/1ps

module acltx_arqbuf #(
    parameter int unsigned LENW = 10
) (
    input  logic           clk_6M,
    input  logic           rstz,
    acltx_arqbuf_if.slave  bus
);

`ifdef ACLTX_ZEROLEN_FLUSH_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_OUT = 2'd1,
        ZERO_OUT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_OUT = 2'd1
    } state_t;
`endif

    state_t          state;
    logic [1:0]      full;
    logic [LENW-1:0] len0;
    logic [LENW-1:0] len1;
    logic            act;
    logic            flush_pend;
    logic            flush_q;
    logic            ack_l;
    logic            flow_l;

    logic            send_new;
    logic            send_old;
    logic            send_null;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
    logic            send_zero;
`endif
    logic            seqn;
    logic [LENW-1:0] pylen;
    logic            rel_p;
    logic            err_p;

    logic            rd_sel;
    logic [LENW-1:0] rd_cnt;

    logic            eff_ack;
    logic            eff_flow;
    logic            nact;
    logic            wr_tgt;
    logic            flush_now;
    logic            rd_adv;
    logic [LENW-1:0] pylen_m1;

    function automatic logic [LENW-1:0] buf_len(input logic sel,
                                                 input logic [LENW-1:0] l0,
                                                 input logic [LENW-1:0] l1);
        return sel ? l1 : l0;
    endfunction

    // A header arriving in the decision cycle takes effect in that decision
    assign eff_ack  = bus.rx_hdr_valid_p ? bus.rx_arqn : ack_l;
    assign eff_flow = bus.rx_hdr_valid_p ? bus.rx_flow : flow_l;

    // Loads go to the active buffer while it is empty, else to the other one
    assign nact   = ~act;
    assign wr_tgt = full[act] ? nact : act;

    // A flush coinciding with a slot is deferred so it only affects the next decision
    assign flush_now = (bus.mcu_flush_p | flush_q) & ~bus.tx_slot_start_p;

    // Byte counter advances per encoder read and saturates on the last byte
    assign pylen_m1 = pylen - LENW'(1);
    assign rd_adv   = bus.py_rd_p & (pylen != '0) & (rd_cnt != pylen_m1);

    // Output mapping
    assign bus.sendnewpy      = send_new;
    assign bus.sendoldpy      = send_old;
    assign bus.sendnull       = send_null;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
    assign bus.send0py        = send_zero;
`else
    assign bus.send0py        = 1'b0;
`endif
    assign bus.txSEQN         = seqn;
    assign bus.txpylen        = pylen;
    assign bus.py_rdaddr      = {rd_sel, rd_cnt};
    assign bus.py_rdlast      = (rd_cnt == pylen_m1) & (pylen != '0);
    assign bus.buf_released_p = rel_p;
    assign bus.bufwr_err_p    = err_p;

    // ARQ state machine, buffer bookkeeping and read counter
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state      <= IDLE;
            full       <= 2'b00;
            len0       <= '0;
            len1       <= '0;
            act        <= 1'b0;
            flush_pend <= 1'b0;
            flush_q    <= 1'b0;
            ack_l      <= 1'b0;
            flow_l     <= 1'b1;
            send_new   <= 1'b0;
            send_old   <= 1'b0;
            send_null  <= 1'b0;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
            send_zero  <= 1'b0;
`endif
            seqn       <= 1'b1;
            pylen      <= '0;
            rel_p      <= 1'b0;
            err_p      <= 1'b0;
            rd_sel     <= 1'b0;
            rd_cnt     <= '0;
        end else if (bus.connsnew_p) begin
            state      <= IDLE;
            full       <= 2'b00;
            len0       <= '0;
            len1       <= '0;
            act        <= 1'b0;
            flush_pend <= 1'b0;
            flush_q    <= 1'b0;
            ack_l      <= 1'b0;
            flow_l     <= 1'b1;
            send_new   <= 1'b0;
            send_old   <= 1'b0;
            send_null  <= 1'b0;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
            send_zero  <= 1'b0;
`endif
            seqn       <= 1'b1;
            pylen      <= '0;
            rel_p      <= 1'b0;
            err_p      <= 1'b0;
            rd_sel     <= 1'b0;
            rd_cnt     <= '0;
        end else begin
            rel_p   <= 1'b0;
            err_p   <= 1'b0;
            flush_q <= (bus.mcu_flush_p | flush_q) & bus.tx_slot_start_p;

            if (bus.rx_hdr_valid_p) begin
                ack_l  <= bus.rx_arqn;
                flow_l <= bus.rx_flow;
            end

            if (rd_adv) begin
                rd_cnt <= rd_cnt + LENW'(1);
            end

            // Slot decision: one-hot outputs held until the next slot
            if (bus.tx_slot_start_p) begin
                ack_l     <= 1'b0;
                rd_cnt    <= '0;
                send_new  <= 1'b0;
                send_old  <= 1'b0;
                send_null <= 1'b0;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
                send_zero <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        if (full[act] && eff_flow) begin
                            send_new <= 1'b1;
                            seqn     <= ~seqn;
                            pylen    <= buf_len(act, len0, len1);
                            rd_sel   <= act;
                            state    <= DATA_OUT;
                        end else begin
                            send_null <= 1'b1;
                            pylen     <= '0;
                        end
                    end
                    DATA_OUT: begin
                        if (eff_ack) begin
                            full[act]  <= 1'b0;
                            rel_p      <= 1'b1;
                            act        <= nact;
                            flush_pend <= 1'b0;
                            if (full[nact] && eff_flow) begin
                                send_new <= 1'b1;
                                seqn     <= ~seqn;
                                pylen    <= buf_len(nact, len0, len1);
                                rd_sel   <= nact;
                            end else begin
                                send_null <= 1'b1;
                                pylen     <= '0;
                                state     <= IDLE;
                            end
                        end else if (!eff_flow) begin
                            send_null <= 1'b1;
                            pylen     <= '0;
                        end else if (flush_pend) begin
                            full[act]  <= 1'b0;
                            rel_p      <= 1'b1;
                            flush_pend <= 1'b0;
                            pylen      <= '0;
`ifdef ACLTX_ZEROLEN_FLUSH_EN
                            send_zero  <= 1'b1;
                            seqn       <= ~seqn;
                            state      <= ZERO_OUT;
`else
                            send_null  <= 1'b1;
                            act        <= nact;
                            state      <= IDLE;
`endif
                        end else begin
                            send_old <= 1'b1;
                            pylen    <= buf_len(act, len0, len1);
                            rd_sel   <= act;
                        end
                    end
`ifdef ACLTX_ZEROLEN_FLUSH_EN
                    ZERO_OUT: begin
                        pylen <= '0;
                        if (eff_ack) begin
                            send_null <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            send_zero <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        send_null <= 1'b1;
                        pylen     <= '0;
                        state     <= IDLE;
                    end
                endcase
            end

            // Flush: drop everything when idle, otherwise finish via the pending flag
            if (flush_now) begin
                if (state == IDLE) begin
                    full  <= 2'b00;
                    rel_p <= 1'b1;
                end else begin
                    flush_pend <= 1'b1;
                    full[nact] <= 1'b0;
                    if (full[nact]) begin
                        rel_p <= 1'b1;
                    end
                end
            end

            // MCU load into the selected buffer; refuse when it is still occupied
            if (bus.mcu_bufwr_p) begin
                if (full[wr_tgt]) begin
                    err_p <= 1'b1;
                end else begin
                    full[wr_tgt] <= 1'b1;
                    if (wr_tgt) begin
                        len1 <= bus.mcu_buflen;
                    end else begin
                        len0 <= bus.mcu_buflen;
                    end
                end
            end
        end
    end

endmodule
